// File: rtl/apb_rr_arbiter_pkg.sv
// Shared FSM encoding, requester limit and width helper for the round-robin APB arbiter.
package apb_rr_arbiter_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'b001,
    ST_SETUP  = 3'b010,
    ST_ACCESS = 3'b100
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Requester-side command/response bundle plus the shared APB master port.
// The arbiter uses the master modport; the requesters and the APB slave sit on the slave side.
interface apb_rr_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) ();
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_write;
  logic [N_REQ*AW-1:0] req_addr;
  logic [N_REQ*DW-1:0] req_wdata;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic                psel;
  logic                penable;
  logic                pwrite;
  logic [AW-1:0]       paddr;
  logic [DW-1:0]       pwdata;
  logic [DW-1:0]       prdata;
  logic                pready;
  logic                pslverr;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_rr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the pointer, wrapping; purely combinational.
// No state and no backpressure; grant is valid in the same cycle as the request vector.
module apb_rr_arbiter_rr_pick
  import apb_rr_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = idx_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [PW-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (k < N) begin
        w_j = PW'((int'(i_ptr) + k) % N);
        if (!o_any && i_req[w_j]) begin
          o_any      = 1'b1;
          o_idx      = w_j;
          o_gnt[w_j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Shares one APB master among N_REQ requesters, round-robin; req_ready to earliest rsp_valid is 3 cycles.
// Requesters hold their command until req_ready; a slow slave stretches ACCESS up to TIMEOUT cycles.
module apb_rr_arbiter
  import apb_rr_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 i_pclk,
  input  logic                 i_prst,
  apb_rr_arbiter_if.master     io_bus
);

  localparam int PW = idx_w(N_REQ);
  localparam int CW = idx_w(TIMEOUT + 1);

  state_t           r_state;
  state_t           w_next;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_idx;
  logic [PW-1:0]    w_idx;
  logic [N_REQ-1:0] w_gnt;
  logic             w_any;
  logic             w_decide;
  logic             w_complete;
  logic             w_timeout;
  logic             r_write;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_wdata;
  logic [CW-1:0]    r_cnt;
  logic [N_REQ-1:0] r_rsp_vld;
  logic [DW-1:0]    r_rsp_rdata;
  logic             r_rsp_err;

  apb_rr_arbiter_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .i_req (io_bus.req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // r_cnt holds the number of wait cycles already spent, so this fires on the TIMEOUT-th ACCESS cycle.
  generate
    if (TIMEOUT > 0) begin : g_to
      assign w_timeout = (r_state == ST_ACCESS) && !io_bus.pready && (r_cnt == CW'(TIMEOUT - 1));
    end else begin : g_no_to
      assign w_timeout = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_pclk) begin
    if (i_prst) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    w_decide         = 1'b0;
    w_complete       = 1'b0;
    io_bus.req_ready = '0;
    io_bus.psel      = 1'b0;
    io_bus.penable   = 1'b0;
    case (r_state)
      ST_IDLE: w_decide = 1'b1;
      ST_SETUP: begin
        io_bus.psel = 1'b1;
        w_next      = ST_ACCESS;
      end
      ST_ACCESS: begin
        io_bus.psel    = 1'b1;
        io_bus.penable = 1'b1;
        w_complete     = io_bus.pready | w_timeout;
        w_decide       = w_complete;
        if (w_complete) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_decide && w_any) begin
      w_next           = ST_SETUP;
      io_bus.req_ready = w_gnt;
    end
  end

  always_ff @(posedge i_pclk) begin
    if (i_prst) begin
      r_ptr       <= '0;
      r_idx       <= '0;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cnt       <= '0;
      r_rsp_vld   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_decide && w_any) begin
        r_ptr   <= (w_idx == PW'(N_REQ - 1)) ? '0 : w_idx + 1'b1;
        r_idx   <= w_idx;
        r_write <= io_bus.req_write[w_idx];
        r_addr  <= io_bus.req_addr[w_idx*AW +: AW];
        r_wdata <= io_bus.req_wdata[w_idx*DW +: DW];
      end
      if (w_next == ST_SETUP) r_cnt <= '0;
      else if (r_state == ST_ACCESS && !io_bus.pready) r_cnt <= r_cnt + 1'b1;
      r_rsp_vld   <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      if (w_complete) begin
        r_rsp_vld   <= N_REQ'(1) << r_idx;
        r_rsp_rdata <= (!r_write && io_bus.pready && !io_bus.pslverr) ? io_bus.prdata : '0;
        r_rsp_err   <= w_timeout | (io_bus.pready & io_bus.pslverr);
      end
    end
  end

  assign io_bus.pwrite    = r_write;
  assign io_bus.paddr     = r_addr;
  assign io_bus.pwdata    = r_wdata;
  assign io_bus.rsp_valid = r_rsp_vld;
  assign io_bus.rsp_rdata = r_rsp_rdata;
  assign io_bus.rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Bench for apb_rr_arbiter: directed scenarios plus a randomized run against a transaction-age model.
module tb_apb_rr_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  apb_rr_arbiter_if #(.N_REQ(N), .AW(AW), .DW(DW)) bus ();

  apb_rr_arbiter #(.N_REQ(N), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .i_pclk (clk),
    .i_prst (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0]  got_c;
    logic [64:0] got_d;
    do_reset();
    bus.req_valid = 4'b0001; bus.req_write = 4'b0001;
    bus.req_addr[31:0] = 32'hABC; bus.req_wdata[31:0] = 32'h55;
    cyc(); bus.req_valid = '0;
    cyc(); rst = 1'b1; bus.pready = 1'b1;
    cyc(); rst = 1'b0; bus.pready = 1'b0;
    #4;
    got_c = {bus.psel, bus.penable, bus.req_ready, bus.rsp_err};
    n_cmp++;
    if (got_c !== 7'b0 || bus.rsp_valid !== 4'b0 || bus.rsp_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_ctl: got ctl=%b rsp_valid=%b rdata=%h want all 0", got_c, bus.rsp_valid, bus.rsp_rdata);
    end
    got_d = {bus.pwrite, bus.paddr, bus.pwdata};
    n_cmp++;
    if (got_d !== 65'b0) begin n_bad++; $display("FAIL reset_cmd: got %h want 0", got_d); end
  endtask

  task automatic test_single_read();
    logic [5:0]  g6;
    logic [34:0] g35;
    do_reset();
    bus.req_valid = 4'b0001; bus.req_addr[31:0] = 32'h10; bus.prdata = 32'hDEADBEEF;
    #4; g6 = {bus.req_ready, bus.psel, bus.penable};
    n_cmp++; if (g6 !== 6'b0001_00) begin n_bad++; $display("FAIL rd_grant: got %b want 000100", g6); end
    cyc(); bus.req_valid = '0; bus.pready = 1'b1;
    #4; g35 = {bus.psel, bus.penable, bus.pwrite, bus.paddr};
    n_cmp++; if (g35 !== {3'b100, 32'h10}) begin n_bad++; $display("FAIL rd_setup: got %h want %h", g35, {3'b100, 32'h10}); end
    cyc(); #4; g6 = {bus.psel, bus.penable, bus.rsp_valid};
    n_cmp++; if (g6 !== 6'b11_0000) begin n_bad++; $display("FAIL rd_access: got %b want 110000", g6); end
    cyc(); bus.pready = 1'b0;
    #4; g6 = {bus.psel, bus.rsp_valid, bus.rsp_err};
    n_cmp++; if (g6 !== 6'b0_0001_0) begin n_bad++; $display("FAIL rd_rsp: got %b want 000010", g6); end
    n_cmp++; if (bus.rsp_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL rd_data: got %h want deadbeef", bus.rsp_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr [N];
    logic [8:0]  got, exp;
    logic [31:0] exp_a;
    do_reset();
    for (int i = 0; i < N; i++) begin addr[i] = $urandom; bus.req_addr[i*AW +: AW] = addr[i]; end
    bus.req_valid = '1; bus.pready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) cyc();
      #4;
      exp = {((c % 2 == 0) ? 4'(1 << ((c / 2) % N)) : 4'b0), (c != 0),
             ((c % 2 == 1 && c >= 3) ? 4'(1 << (((c - 3) / 2) % N)) : 4'b0)};
      got = {bus.req_ready, bus.psel, bus.rsp_valid};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL b2b_c%0d: got %b want %b", c, got, exp); end
      if (c % 2 == 1) begin
        exp_a = addr[((c - 1) / 2) % N];
        n_cmp++; if (bus.paddr !== exp_a) begin n_bad++; $display("FAIL b2b_addr_c%0d: got %h want %h", c, bus.paddr, exp_a); end
      end
    end
  endtask

  task automatic test_wait_states();
    logic [65:0] got;
    logic [37:0] g38;
    int n_en;
    do_reset();
    bus.req_valid = 4'b0100; bus.req_write = 4'b0100;
    bus.req_addr[2*AW +: AW] = 32'h44; bus.req_wdata[2*DW +: DW] = 32'hA5A5;
    #4;
    n_cmp++; if (bus.req_ready !== 4'b0100) begin n_bad++; $display("FAIL ws_grant: got %b want 0100", bus.req_ready); end
    cyc(); bus.req_valid = '0;
    #4;
    n_cmp++; if ({bus.psel, bus.penable} !== 2'b10) begin n_bad++; $display("FAIL ws_setup: got %b want 10", {bus.psel, bus.penable}); end
    n_en = 0;
    for (int c = 2; c <= 6; c++) begin
      cyc(); bus.pready = (c == 5);
      #4;
      if (bus.penable) n_en++;
      if (c <= 5) begin
        got = {bus.psel, bus.pwrite, bus.paddr, bus.pwdata};
        n_cmp++; if (got !== {2'b11, 32'h44, 32'hA5A5}) begin n_bad++; $display("FAIL ws_stable_c%0d: got %h want %h", c, got, {2'b11, 32'h44, 32'hA5A5}); end
      end
    end
    n_cmp++; if (n_en != 4) begin n_bad++; $display("FAIL ws_penable_cycles: got %0d want 4", n_en); end
    g38 = {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    n_cmp++; if (g38 !== {1'b0, 4'b0100, 1'b0, 32'h0}) begin n_bad++; $display("FAIL ws_rsp: got %h want %h", g38, {1'b0, 4'b0100, 1'b0, 32'h0}); end
  endtask

  task automatic test_slverr();
    logic [36:0] got;
    do_reset();
    bus.req_valid = 4'b0010; bus.req_addr[1*AW +: AW] = 32'h20;
    #4;
    n_cmp++; if (bus.req_ready !== 4'b0010) begin n_bad++; $display("FAIL se_grant: got %b want 0010", bus.req_ready); end
    cyc(); bus.req_valid = '0; bus.pready = 1'b1; bus.pslverr = 1'b1; bus.prdata = 32'h12345678;
    cyc();
    cyc(); bus.pready = 1'b0; bus.pslverr = 1'b0;
    #4; got = {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    n_cmp++; if (got !== {4'b0010, 1'b1, 32'h0}) begin n_bad++; $display("FAIL se_rsp: got %h want %h", got, {4'b0010, 1'b1, 32'h0}); end
  endtask

  task automatic test_timeout();
    logic [7:0]  g8;
    logic [70:0] g71;
    logic [37:0] g38;
    int n_en;
    do_reset();
    bus.req_valid = 4'b1001; bus.prdata = 32'hCAFE0000;
    bus.req_addr[0 +: AW] = 32'h100; bus.req_addr[3*AW +: AW] = 32'h300;
    #4;
    n_cmp++; if (bus.req_ready !== 4'b0001) begin n_bad++; $display("FAIL to_grant0: got %b want 0001", bus.req_ready); end
    n_en = 0;
    for (int c = 1; c <= 9; c++) begin
      cyc(); if (c == 1) bus.req_valid = 4'b1000;
      #4;
      if (bus.penable) n_en++;
      g8 = {bus.req_ready, bus.rsp_valid};
      n_cmp++; if (g8 !== {((c == 9) ? 4'b1000 : 4'b0), 4'b0}) begin n_bad++; $display("FAIL to_wait_c%0d: got %b want %b", c, g8, {((c == 9) ? 4'b1000 : 4'b0), 4'b0}); end
    end
    n_cmp++; if (n_en != TO) begin n_bad++; $display("FAIL to_access_cycles: got %0d want %0d", n_en, TO); end
    cyc(); bus.req_valid = '0; bus.pready = 1'b1;
    #4; g71 = {bus.psel, bus.penable, bus.paddr, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    n_cmp++; if (g71 !== {2'b10, 32'h300, 4'b0001, 1'b1, 32'h0}) begin n_bad++; $display("FAIL to_rsp: got %h want %h", g71, {2'b10, 32'h300, 4'b0001, 1'b1, 32'h0}); end
    cyc(); #4;
    n_cmp++; if (bus.penable !== 1'b1) begin n_bad++; $display("FAIL to_req3_access: got %b want 1", bus.penable); end
    cyc(); bus.pready = 1'b0;
    #4; g38 = {bus.psel, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
    n_cmp++; if (g38 !== {1'b0, 4'b1000, 1'b0, 32'hCAFE0000}) begin n_bad++; $display("FAIL to_req3_rsp: got %h want %h", g38, {1'b0, 4'b1000, 1'b0, 32'hCAFE0000}); end
  endtask

  task automatic test_reset_mid();
    logic [9:0] g10;
    logic [5:0] g6;
    do_reset();
    bus.req_valid = 4'b0001; bus.req_addr[31:0] = 32'h80;
    cyc(); bus.req_valid = '0;
    cyc(); #4;
    n_cmp++; if (bus.penable !== 1'b1) begin n_bad++; $display("FAIL rm_access1: got %b want 1", bus.penable); end
    cyc(); rst = 1'b1; bus.pready = 1'b1; bus.prdata = 32'hFFFF;
    cyc(); rst = 1'b0; bus.pready = 1'b0; bus.req_valid = '1;
    #4; g10 = {bus.psel, bus.penable, bus.rsp_valid, bus.req_ready};
    n_cmp++; if (g10 !== {2'b00, 4'b0000, 4'b0001}) begin n_bad++; $display("FAIL rm_after: got %b want 0000000001", g10); end
    cyc(); bus.req_valid = '0;
    #4; g6 = {bus.psel, bus.penable, bus.rsp_valid};
    n_cmp++; if (g6 !== 6'b10_0000) begin n_bad++; $display("FAIL rm_regrant: got %b want 100000", g6); end
  endtask

  // Model tracks the active transfer by owner and age since grant (1 = setup, k+1 = k-th access cycle).
  task automatic test_random();
    bit          rv [N];
    bit          rw [N];
    logic [31:0] ra [N];
    logic [31:0] rd [N];
    int m_cur, m_age, m_ptr, m_wait, acc, g;
    bit m_w, to, done, decide;
    logic [31:0] m_a, m_d, e_dat;
    logic [3:0]  e_rv, exp_rdy;
    logic        e_err;
    logic [5:0]  got6, exp6;
    logic [64:0] got65, exp65;
    logic [36:0] got37, exp37;
    do_reset();
    m_cur = -1; m_age = 0; m_ptr = 0; m_wait = 0; m_w = 0; m_a = 0; m_d = 0;
    e_rv = 0; e_err = 0; e_dat = 0;
    for (int i = 0; i < N; i++) begin rv[i] = 0; rw[i] = 0; ra[i] = 0; rd[i] = 0; end
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) cyc();
      for (int i = 0; i < N; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            rv[i] = 1; rw[i] = 1'($urandom_range(0, 1)); ra[i] = $urandom; rd[i] = $urandom;
          end
        end else if ($urandom_range(0, 19) == 0) rv[i] = 0;
        bus.req_valid[i] = rv[i]; bus.req_write[i] = rw[i];
        bus.req_addr[i*AW +: AW] = ra[i]; bus.req_wdata[i*DW +: DW] = rd[i];
      end
      acc = (m_cur >= 0 && m_age >= 2) ? m_age - 1 : 0;
      bus.pready  = (acc > 0) ? (acc > m_wait) : 1'($urandom_range(0, 1));
      bus.pslverr = ($urandom_range(0, 3) == 0);
      bus.prdata  = $urandom;
      #4;
      to     = (acc > 0) && !bus.pready && (acc == TO);
      done   = (acc > 0) && (bus.pready || to);
      decide = (m_cur < 0) || done;
      g = -1;
      if (decide) for (int k = 0; k < N; k++) if (g < 0 && rv[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0;
      got6 = {bus.req_ready, bus.psel, bus.penable};
      exp6 = {exp_rdy, (m_cur >= 0), (acc > 0)};
      n_cmp++; if (got6 !== exp6) begin n_bad++; $display("FAIL rnd_ctl c%0d: got %b want %b", c, got6, exp6); end
      if (m_cur >= 0) begin
        got65 = {bus.pwrite, bus.paddr, bus.pwdata};
        exp65 = {m_w, m_a, m_d};
        n_cmp++; if (got65 !== exp65) begin n_bad++; $display("FAIL rnd_cmd c%0d: got %h want %h", c, got65, exp65); end
      end
      got37 = {bus.rsp_valid, bus.rsp_err, bus.rsp_rdata};
      exp37 = {e_rv, e_err, e_dat};
      n_cmp++; if (got37 !== exp37) begin n_bad++; $display("FAIL rnd_rsp c%0d: got %h want %h", c, got37, exp37); end
      if (done) begin
        e_rv  = 4'(1 << m_cur);
        e_err = to | (bus.pready & bus.pslverr);
        e_dat = (!m_w && bus.pready && !bus.pslverr) ? bus.prdata : 32'h0;
      end else begin
        e_rv = 0; e_err = 0; e_dat = 0;
      end
      if (g >= 0) begin
        m_cur = g; m_age = 1; m_w = rw[g]; m_a = ra[g]; m_d = rd[g];
        m_ptr = (g + 1) % N;
        m_wait = ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(0, 3);
        rv[g] = 0;
      end else if (done) m_cur = -1;
      else if (m_cur >= 0) m_age++;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_wait_states();
    test_slverr();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
